shift_cmd_ctrl: RTL

//  Command sequencer for a WIDTH-bit bidirectional shift register.
//  - Accepts one shift command over a valid/ready handshake: direction, shift count, serial bits.
//  - Drives the register's shift-left/shift-right/serial-in controls for exactly the commanded number of cycles.
//  - Returns the resulting register contents over a valid/ready response handshake.
//  - Sits between a host/CSR sequencer and the shift datapath; the register holds its value between commands.

---
 rtl/shift_cmd_ctrl_pkg.sv | 15 +
 rtl/shift_cmd_ctrl_core.sv | 26 ++
 rtl/shift_cmd_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/shift_cmd_ctrl_pkg.sv
// Shared types and constants for the shift command controller.
package shift_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Shift direction encoding of cmd_dir
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_cmd_ctrl_core.sv
// Bidirectional WIDTH-bit shift register; holds when l and r agree.
module bidir_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             l,
  input  logic             r,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  // Shift register: left moves toward MSB with d at q[0], right moves toward LSB with d at MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (l && !r) begin
      q <= {q[WIDTH-2:0], d};
    end else if (r && !l) begin
      q <= {d, q[WIDTH-1:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/shift_cmd_ctrl.sv
// Command sequencer: accepts one shift command, drives the shift core for
// the clamped number of cycles, then presents the register contents.
module shift_cmd_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic             busy,
  output logic             l,
  output logic             r,
  output logic             d
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_len;
  logic [WIDTH-1:0] w_q;

  // Requests longer than the register are clamped to a full-width shift
  always_comb begin
    w_len = cmd_len;
    if (cmd_len > LEN_MAX) begin
      w_len = LEN_MAX;
    end else begin
      w_len = cmd_len;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; outputs depend only on registered state and data
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    l            = 1'b0;
    r            = 1'b0;
    d            = 1'b0;
    rsp_valid    = 1'b0;
    rsp_q        = '0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_len == '0) begin
            w_next_state = RESP;
          end else begin
            w_next_state = SHIFT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        l    = (r_dir == DIR_LEFT);
        r    = (r_dir == DIR_RIGHT);
        d    = r_data[0];
        if (r_cnt == CNT_ONE) begin
          w_next_state = RESP;
        end else begin
          w_next_state = SHIFT;
        end
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_q     = w_q;
        if (rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Command capture on acceptance; serial data and count consumed one per shift cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= DIR_LEFT;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_dir  <= cmd_dir;
            r_data <= cmd_data;
            r_cnt  <= w_len;
          end else begin
            r_dir  <= r_dir;
            r_data <= r_data;
            r_cnt  <= r_cnt;
          end
        end
        SHIFT: begin
          r_data <= {1'b0, r_data[WIDTH-1:1]};
          r_cnt  <= r_cnt - CNT_ONE;
        end
        default: begin
          r_dir  <= r_dir;
          r_data <= r_data;
          r_cnt  <= r_cnt;
        end
      endcase
    end
  end

  bidir_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .l    (l),
    .r    (r),
    .d    (d),
    .q    (w_q)
  );

endmodule
